load_store_unit: RTL
====================

# load_store_unit

Memory-side initiator for the single-port `data_memory`: it accepts one load or store request at a time from the core and drives the memory's `addr`/`wd`/`we`/`MemRead` pins. It implements RISC-V LB/LH/LW/LBU/LHU/SB/SH/SW on a word-only memory. Sub-word stores use read-modify-write. Loads are sign- or zero-extended. Sits between the execute stage and `data_memory`.

## Interface
Parameters:
- `DATA_WIDTH`, default `` `DATA_WIDTH `` (32 from defs.vh): data and address width. Only 32 is supported.

Ports:
- `clk`, input, 1: rising-edge clock.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `req_valid`, input, 1: request present.
- `req_ready`, output, 1: block is idle and accepts a request. A request is accepted on an edge where `req_valid && req_ready`.
- `req_store`, input, 1: 1 = store, 0 = load.
- `req_funct3`, input, 3: RISC-V funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU).
- `req_addr`, input, DATA_WIDTH: byte address.
- `req_wdata`, input, DATA_WIDTH: store data, right-aligned.
- `resp_valid`, output, 1: one-cycle completion pulse.
- `resp_err`, output, 1: misaligned or illegal request. Valid with `resp_valid`.
- `resp_rdata`, output, DATA_WIDTH: extended load data. Valid with `resp_valid`.
- `mem_addr`, output, DATA_WIDTH: word-aligned byte address, `{addr[31:2],2'b00}`.
- `mem_wd`, output, DATA_WIDTH: write data.
- `mem_we`, output, 1: memory write enable.
- `mem_read`, output, 1: memory read enable (`MemRead`).
- `mem_rd`, input, DATA_WIDTH: memory read data.

## Operation
- Request capture: on acceptance, `req_store`, `req_funct3`, `req_addr` and `req_wdata` are latched. Later changes on the request inputs are ignored.
- States are IDLE, RD, LATCH, WR, DONE.
- IDLE:
  - `req_ready`=1; all memory outputs are 0.
  - On acceptance, an illegal or misaligned request goes to DONE with the error flag set.
  - Otherwise: SW goes to WR; any load, SB or SH goes to RD.
- RD: `mem_read`=1 with `mem_addr` driven. Goes to LATCH.
- LATCH:
  - `mem_read`=1 and `mem_addr` are held.
  - `mem_rd` is registered at the closing edge.
  - Loads then go to DONE; SB/SH go to WR.
- WR:
  - `mem_we`=1 for exactly one cycle.
  - SW: `mem_wd` = latched wdata.
  - SB: `mem_wd` = latched word with byte lane `addr[1:0]` replaced by `wdata[7:0]`.
  - SH: `mem_wd` = latched word with half `addr[1]` replaced by `wdata[15:0]`.
  - Goes to DONE.
- DONE: `resp_valid`=1 for one cycle, then IDLE. There is no response backpressure.
- Load extraction:
  - The byte or halfword is selected by `addr[1:0]`.
  - LB/LH sign-extend to 32 bits; LBU/LHU zero-extend; LW passes the word through.
  - Stores return `resp_rdata`=0.
- Illegal or misaligned requests:
  - Illegal funct3: load funct3 011/110/111; store funct3 ≥ 011.
  - Misaligned: H/HU with `addr[0]`=1; W with `addr[1:0]`≠0.
  - Response: `resp_err`=1, `resp_rdata`=0, and no memory access (`mem_we`/`mem_read` never assert).

## Timing
- Reset while `rst_n`=0: state is IDLE immediately.
  - 0: `resp_valid`, `resp_err`, `resp_rdata`, `mem_we`, `mem_read`, `mem_addr`, `mem_wd`.
  - 1: `req_ready`.
- Reset mid-operation:
  - `mem_we` and `mem_read` drop asynchronously and the operation is abandoned with no response.
  - A WR edge already taken remains in memory; otherwise memory is untouched.
- Latency, in cycles from the acceptance edge to `resp_valid` high:
  - SW: 2 (WR, DONE).
  - Loads: 3 (RD, LATCH, DONE).
  - SB/SH: 4 (RD, LATCH, WR, DONE).
  - Error: 1 (DONE).
- `req_ready` is low from the cycle after acceptance through DONE inclusive. The next request can be accepted on the edge ending the first IDLE cycle.
- During RD/LATCH/WR, `mem_addr` is constant.
- `mem_wd` is 0 outside WR.
- `mem_we` and `mem_read` are never high together.
- Memory contract: `mem_rd` must be valid by the end of the second `mem_read` cycle. This covers both combinational-read and 1-cycle-registered-read memories.

## Test plan
- SW 0xDEADBEEF @0x28, then LW @0x28:
  - `mem_we` is high for exactly 1 cycle.
  - The LW response arrives 3 cycles after acceptance with `resp_rdata`=DEADBEEF and `resp_err`=0.
- SB 0x000000AA @0x29 after the above, then LW @0x28 → DEADAAEF. SB `resp_valid` arrives 4 cycles after acceptance.
- On word DEADAAEF @0x28:
  - LB @0x29 → FFFFFFAA.
  - LBU @0x29 → 000000AA.
  - LH @0x2A → FFFFDEAD.
  - LHU @0x2A → 0000DEAD.
- SH 0x1234 @0x2B and LW @0x2A:
  - `resp_err`=1 one cycle after acceptance, with `mem_we`/`mem_read` never asserted.
  - A following LW @0x28 still returns DEADAAEF.
- LW @0x50 on an unwritten word → 00000000; `req_valid` held high back-to-back gets its next acceptance one cycle after DONE.
- SB @0x28 with `rst_n` pulled low during LATCH:
  - `mem_read` drops immediately and no `resp_valid` is produced.
  - After release `req_ready`=1, and LW @0x28 returns the pre-SB value.

Source files
------------

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - single-request load/store initiator for a word-only data memory
module load_store_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_store,
  input  logic [2:0]            req_funct3,
  input  logic [DATA_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic                  resp_err,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wd,
  output logic                  mem_we,
  output logic                  mem_read,
  input  logic [DATA_WIDTH-1:0] mem_rd
);

  typedef enum logic [2:0] {IDLE, RD, LATCH, WR, DONE} state_t;

  state_t      state;
  logic        op_store;
  logic [2:0]  op_funct3;
  logic [1:0]  op_lane;
  logic [15:0] op_wdata;

  logic                  req_illegal;
  logic                  req_misaligned;
  logic [7:0]            rd_byte;
  logic [15:0]           rd_half;
  logic [DATA_WIDTH-1:0] load_ext;
  logic [DATA_WIDTH-1:0] merged_word;

  // Classify the incoming request: unsupported funct3 or an address that is not naturally aligned
  always_comb begin
    req_illegal    = 1'b0;
    req_misaligned = 1'b0;
    if (req_store)
      req_illegal = req_funct3[2] || (req_funct3[1:0] == 2'b11);
    else
      req_illegal = (req_funct3[1:0] == 2'b11) || (req_funct3 == 3'b110);
    if (req_funct3[1:0] == 2'b01 && req_addr[0])
      req_misaligned = 1'b1;
    if (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00)
      req_misaligned = 1'b1;
  end

  // Pick the addressed byte/half out of the memory word and extend it for the load response
  always_comb begin
    rd_byte  = 8'h00;
    rd_half  = op_lane[1] ? mem_rd[31:16] : mem_rd[15:0];
    load_ext = mem_rd;
    case (op_lane)
      2'd0: rd_byte = mem_rd[7:0];
      2'd1: rd_byte = mem_rd[15:8];
      2'd2: rd_byte = mem_rd[23:16];
      default: rd_byte = mem_rd[31:24];
    endcase
    case (op_funct3)
      3'b000: load_ext = {{24{rd_byte[7]}}, rd_byte};
      3'b001: load_ext = {{16{rd_half[15]}}, rd_half};
      3'b100: load_ext = {24'h000000, rd_byte};
      3'b101: load_ext = {16'h0000, rd_half};
      default: load_ext = mem_rd;
    endcase
  end

  // Read-modify-write merge: drop the store byte/half into the freshly read word
  always_comb begin
    merged_word = mem_rd;
    if (op_funct3[1:0] == 2'b00) begin
      case (op_lane)
        2'd0: merged_word[7:0]   = op_wdata[7:0];
        2'd1: merged_word[15:8]  = op_wdata[7:0];
        2'd2: merged_word[23:16] = op_wdata[7:0];
        default: merged_word[31:24] = op_wdata[7:0];
      endcase
    end else begin
      if (op_lane[1])
        merged_word[31:16] = op_wdata;
      else
        merged_word[15:0] = op_wdata;
    end
  end

  // Request sequencer; every port output is a register so memory pins never glitch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      op_store   <= 1'b0;
      op_funct3  <= 3'b000;
      op_lane    <= 2'b00;
      op_wdata   <= 16'h0000;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      mem_addr   <= '0;
      mem_wd     <= '0;
      mem_we     <= 1'b0;
      mem_read   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            op_store  <= req_store;
            op_funct3 <= req_funct3;
            op_lane   <= req_addr[1:0];
            op_wdata  <= req_wdata[15:0];
            req_ready <= 1'b0;
            if (req_illegal || req_misaligned) begin
              // No memory traffic at all for a rejected request
              state      <= DONE;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end else if (req_store && req_funct3 == 3'b010) begin
              // Full-word store needs no read, go straight to the write cycle
              state    <= WR;
              mem_we   <= 1'b1;
              mem_addr <= {req_addr[DATA_WIDTH-1:2], 2'b00};
              mem_wd   <= req_wdata;
            end else begin
              state    <= RD;
              mem_read <= 1'b1;
              mem_addr <= {req_addr[DATA_WIDTH-1:2], 2'b00};
            end
          end
        end
        RD: begin
          // Second read cycle gives a registered-read memory time to present data
          state <= LATCH;
        end
        LATCH: begin
          mem_read <= 1'b0;
          if (op_store) begin
            state  <= WR;
            mem_we <= 1'b1;
            mem_wd <= merged_word;
          end else begin
            state      <= DONE;
            mem_addr   <= '0;
            resp_valid <= 1'b1;
            resp_rdata <= load_ext;
          end
        end
        WR: begin
          state      <= DONE;
          mem_we     <= 1'b0;
          mem_wd     <= '0;
          mem_addr   <= '0;
          resp_valid <= 1'b1;
          resp_rdata <= '0;
        end
        DONE: begin
          state      <= IDLE;
          req_ready  <= 1'b1;
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          resp_rdata <= '0;
        end
        default: begin
          state      <= IDLE;
          req_ready  <= 1'b1;
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          resp_rdata <= '0;
          mem_addr   <= '0;
          mem_wd     <= '0;
          mem_we     <= 1'b0;
          mem_read   <= 1'b0;
        end
      endcase
    end
  end

endmodule
